// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/write-back
// over a shared memory port, counts retired instructions and traps on bad opcodes.
module multicycle_control #(
    parameter bit SUPPORT_ALU_IMM = 1'b1,
    parameter bit SUPPORT_JAL     = 1'b1,
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             branch_o,
    output logic             done_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] instret_o
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_ILLEGAL
    } state_t;

    state_t state, state_nxt;
    logic             ready;
    logic             pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write;
    logic             branch, done, trap;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
    logic [CNT_W-1:0] instret;

    assign ready = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     instret <= '0;
        else if (done) instret <= instret + CNT_W'(1);
    end

    always_comb begin
        state_nxt  = state;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        branch     = 1'b0;
        done       = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                // PC+4 is computed while the fetch is outstanding; commit only on ready
                mem_read  = 1'b1;
                alu_src_b = 2'b10;
                if (ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode_i)
                    OP_R:         state_nxt = S_EXEC_R;
                    OP_I:         state_nxt = SUPPORT_ALU_IMM ? S_EXEC_I : S_ILLEGAL;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_BR:        state_nxt = S_BRANCH;
                    OP_JAL:       state_nxt = SUPPORT_JAL ? S_JAL : S_ILLEGAL;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                done       = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (ready) begin
                    done      = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 1'b1;
                done      = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b11;
                done       = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ILLEGAL: trap = 1'b1;
            default:   state_nxt = S_ILLEGAL;
        endcase
    end

    // Reset masks every output combinationally, so it takes effect without a clock edge
    assign pc_write_o   = pc_write  & ~rst_i;
    assign pc_src_o     = pc_src    & ~rst_i;
    assign ir_write_o   = ir_write  & ~rst_i;
    assign iord_o       = iord      & ~rst_i;
    assign mem_read_o   = mem_read  & ~rst_i;
    assign mem_write_o  = mem_write & ~rst_i;
    assign reg_write_o  = reg_write & ~rst_i;
    assign branch_o     = branch    & ~rst_i;
    assign done_o       = done      & ~rst_i;
    assign trap_o       = trap      & ~rst_i;
    assign result_src_o = rst_i ? 2'b00 : result_src;
    assign alu_src_a_o  = rst_i ? 2'b00 : alu_src_a;
    assign alu_src_b_o  = rst_i ? 2'b00 : alu_src_b;
    assign alu_op_o     = rst_i ? 2'b00 : alu_op;
    assign instret_o    = instret;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction-level model expands each
// instruction into its expected per-cycle output schedule and checks every cycle.
module tb_multicycle_control;
    typedef struct packed {
        logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write;
        logic [1:0] result_src, a, b, op;
        logic       branch, done, trap;
    } ovec_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;
    localparam int KF_W = 0, KF = 1, KDEC = 2, KMA = 3, KMR = 4, KMWB = 5, KMW_W = 6;
    localparam int KMW = 7, KEXR = 8, KEXI = 9, KAWB = 10, KBR = 11, KJAL = 12, KILL = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode = '0;
    logic        mem_ready = 1'b0;
    bit          sel = 1'b0;
    bit          chk_en = 1'b0;
    ovec_t       exp_o = '0;
    logic [31:0] cnt = '0;
    int          total = 0, bad = 0;
    int          ncyc = 0, rw_at = 0, br_at = 0, dn_at = 0, mr_cnt = 0, mw_cnt = 0;

    wire [1:0]      pcw, pcs, irw, io, mr, mw, rw, br, dn, tr;
    wire [1:0][1:0] rs, sa, sb, aop;
    wire [31:0]     cnt1;
    wire [3:0]      cnt2;
    ovec_t          act;
    logic [31:0]    act_cnt;

    always #5 clk = ~clk;

    multicycle_control u_dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(pcw[0]), .pc_src_o(pcs[0]), .ir_write_o(irw[0]), .iord_o(io[0]),
        .mem_read_o(mr[0]), .mem_write_o(mw[0]), .reg_write_o(rw[0]),
        .result_src_o(rs[0]), .alu_src_a_o(sa[0]), .alu_src_b_o(sb[0]), .alu_op_o(aop[0]),
        .branch_o(br[0]), .done_o(dn[0]), .trap_o(tr[0]), .instret_o(cnt1)
    );

    multicycle_control #(.SUPPORT_ALU_IMM(1'b1), .SUPPORT_JAL(1'b0), .MEM_HANDSHAKE(1'b0), .CNT_W(4)) u_var (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(pcw[1]), .pc_src_o(pcs[1]), .ir_write_o(irw[1]), .iord_o(io[1]),
        .mem_read_o(mr[1]), .mem_write_o(mw[1]), .reg_write_o(rw[1]),
        .result_src_o(rs[1]), .alu_src_a_o(sa[1]), .alu_src_b_o(sb[1]), .alu_op_o(aop[1]),
        .branch_o(br[1]), .done_o(dn[1]), .trap_o(tr[1]), .instret_o(cnt2)
    );

    always_comb begin
        act = {pcw[sel], pcs[sel], irw[sel], io[sel], mr[sel], mw[sel], rw[sel],
               rs[sel], sa[sel], sb[sel], aop[sel], br[sel], dn[sel], tr[sel]};
        act_cnt = sel ? {28'b0, cnt2} : cnt1;
    end

    // Required outputs for one cycle of each instruction phase
    function automatic ovec_t ov(input int k);
        ovec_t o = '0;
        case (k)
            KF_W:  begin o.mem_read = 1; o.b = 2'b10; end
            KF:    begin o.mem_read = 1; o.b = 2'b10; o.ir_write = 1; o.pc_write = 1; end
            KDEC:  begin o.a = 2'b01; o.b = 2'b01; end
            KMA:   begin o.a = 2'b10; o.b = 2'b01; end
            KMR:   begin o.mem_read = 1; o.iord = 1; end
            KMWB:  begin o.reg_write = 1; o.result_src = 2'b01; o.done = 1; end
            KMW_W: begin o.mem_write = 1; o.iord = 1; end
            KMW:   begin o.mem_write = 1; o.iord = 1; o.done = 1; end
            KEXR:  begin o.a = 2'b10; o.op = 2'b10; end
            KEXI:  begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; end
            KAWB:  begin o.reg_write = 1; o.done = 1; end
            KBR:   begin o.a = 2'b10; o.op = 2'b01; o.branch = 1; o.pc_src = 1; o.done = 1; end
            KJAL:  begin o.pc_write = 1; o.pc_src = 1; o.reg_write = 1; o.result_src = 2'b11; o.done = 1; end
            KILL:  o.trap = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic cyc(input logic rdy, input int k);
        mem_ready = rdy;
        exp_o     = ov(k);
        chk_en    = 1'b1;
        @(posedge clk);
        if (exp_o.done) cnt = (cnt + 32'd1) & (sel ? 32'h0000_000F : 32'hFFFF_FFFF);
        #1;
    endtask

    // Expand one instruction into cycles; fw/mw are wait cycles, nill the trap cycles to watch
    task automatic do_instr(input logic [6:0] op, input int fw, input int mwt, input int nill);
        bit mh = (sel == 1'b0);
        bit sj = (sel == 1'b0);
        logic r1 = mh;
        opcode = op;
        if (mh) repeat (fw) cyc(1'b0, KF_W);
        cyc(r1, KF);
        cyc(r1, KDEC);
        case (op)
            OP_R:  begin cyc(r1, KEXR); cyc(r1, KAWB); end
            OP_I:  begin cyc(r1, KEXI); cyc(r1, KAWB); end
            OP_LW: begin
                cyc(r1, KMA);
                if (mh) repeat (mwt) cyc(1'b0, KMR);
                cyc(r1, KMR);
                cyc(r1, KMWB);
            end
            OP_SW: begin
                cyc(r1, KMA);
                if (mh) repeat (mwt) cyc(1'b0, KMW_W);
                cyc(r1, KMW);
            end
            OP_BR: cyc(r1, KBR);
            OP_JAL: begin
                if (sj) cyc(r1, KJAL);
                else repeat (nill) cyc(r1, KILL);
            end
            default: repeat (nill) cyc(r1, KILL);
        endcase
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        lit("rst_outputs_zero", 32'(act), 32'd0);
        lit("rst_instret_zero", act_cnt, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = '0;
    endtask

    // Per-cycle compare against the model schedule
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            ncyc++;
            total++;
            if (act !== exp_o) begin
                bad++;
                $display("FAIL outputs cyc=%0d got=%h want=%h", ncyc, act, exp_o);
            end
            total++;
            if (act_cnt !== cnt) begin
                bad++;
                $display("FAIL instret cyc=%0d got=%0d want=%0d", ncyc, act_cnt, cnt);
            end
            if (act.reg_write) rw_at = ncyc;
            if (act.branch)    br_at = ncyc;
            if (act.done)      dn_at = ncyc;
            if (act.mem_read)  mr_cnt++;
            if (act.mem_write) mw_cnt++;
        end
    end

    initial begin
        int g0, m0;
        logic [31:0] c_before;
        #2;
        do_reset();

        // R-type, ready tied high
        g0 = ncyc;
        do_instr(OP_R, 0, 0, 0);
        lit("rtype_regwrite_cycle", 32'(rw_at - g0), 32'd4);
        lit("rtype_instret", cnt1, 32'd1);

        // LW with 2 fetch waits and 3 read waits
        g0 = ncyc; m0 = mr_cnt;
        do_instr(OP_LW, 2, 3, 0);
        lit("lw_done_cycle", 32'(dn_at - g0), 32'd10);
        lit("lw_memread_cycles", 32'(mr_cnt - m0), 32'd7);
        lit("lw_instret", cnt1, 32'd2);

        // SW, BEQ, JAL back to back after a fresh reset
        do_reset();
        g0 = ncyc; m0 = mw_cnt;
        do_instr(OP_SW, 0, 0, 0);
        do_instr(OP_BR, 0, 0, 0);
        do_instr(OP_JAL, 0, 0, 0);
        lit("seq_done_cycle", 32'(dn_at - g0), 32'd10);
        lit("seq_branch_cycle", 32'(br_at - g0), 32'd7);
        lit("seq_memwrite_pulses", 32'(mw_cnt - m0), 32'd1);
        lit("seq_instret", cnt1, 32'd3);
        do_instr(OP_I, 1, 0, 0);
        lit("itype_instret", cnt1, 32'd4);

        // Illegal opcode: trap, no further fetches
        m0 = mr_cnt;
        do_instr(OP_BAD, 0, 0, 20);
        lit("illegal_trap", 32'(tr[0]), 32'd1);
        lit("illegal_fetches", 32'(mr_cnt - m0), 32'd1);
        do_reset();
        do_instr(OP_R, 0, 0, 0);
        lit("restart_instret", cnt1, 32'd1);

        // Asynchronous reset in the middle of a store
        opcode = OP_SW;
        cyc(1'b1, KF); cyc(1'b1, KDEC); cyc(1'b1, KMA);
        chk_en = 1'b0; mem_ready = 1'b0;
        #1;
        lit("sw_memwrite_before_rst", 32'(mw[0]), 32'd1);
        c_before = cnt1;
        lit("sw_instret_not_retired", c_before, 32'd1);
        rst = 1'b1;
        #1;
        lit("sw_memwrite_async_drop", 32'(mw[0]), 32'd0);
        do_reset();

        // Variant: no JAL, no handshake, 4-bit counter
        sel = 1'b1;
        do_reset();
        g0 = ncyc;
        do_instr(OP_LW, 2, 3, 0);
        lit("nohs_lw_done_cycle", 32'(dn_at - g0), 32'd5);
        repeat (15) do_instr(OP_R, 0, 0, 0);
        lit("cnt4_wrap", 32'(cnt2), 32'd0);
        do_instr(OP_JAL, 0, 0, 3);
        lit("nojal_trap", 32'(tr[1]), 32'd1);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
